nios2_oci_dct_capture: RTL and testbench

Parametrised capture-and-drain monitor for the Nios II OCI debug-control-trace (DCT) stream. It sits beside the OCI in simulation and debug builds and detects each new DCT entry from a change in `dct_count`. Each entry is buffered in a first-word-fall-through FIFO for a host-side reader. The FIFO is drained under the `test_ending` / `test_has_ended` protocol, with a sticky overflow flag and an accepted-word total.

---
 rtl/nios2_oci_dct_pkg.sv | 15 +
 rtl/nios2_oci_dct_fifo.sv | 86 ++++++++
 rtl/nios2_oci_dct_capture.sv | 151 +++++++++++++++
 tb/tb_nios2_oci_dct_capture.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and helpers for the Nios II OCI DCT capture monitor.
package nios2_oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } dct_state_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// First-word-fall-through FIFO with flush; a push while full is accepted only
// together with a pop in the same cycle.
module nios2_oci_dct_fifo
  import nios2_oci_dct_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [W-1:0]                  data_i,
  output logic [W-1:0]                  head_o,
  output logic [lvl_width(DEPTH)-1:0]   level_o,
  output logic                          empty_o,
  output logic                          full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          wr_en_s;
  logic          rd_en_s;

  assign empty_o = (level_q == LW'(0));
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign wr_en_s = push_i && (!full_o || pop_i) && !flush_i;
  assign rd_en_s = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = LW'(0);
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (wr_en_s && !rd_en_s) begin
        level_d = level_q + LW'(1);
      end else if (rd_en_s && !wr_en_s) begin
        level_d = level_q - LW'(1);
      end else begin
        level_d = level_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is gated off whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// Captures each new OCI DCT entry (signalled by a dct_count change) into a FWFT
// FIFO and drains it under the test_ending / test_has_ended protocol.
module nios2_oci_dct_capture
  import nios2_oci_dct_pkg::*;
#(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4,
  parameter int DEPTH = 16,
  parameter int TOT_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DCT_W-1:0]              dct_buffer,
  input  logic [CNT_W-1:0]              dct_count,
  input  logic                          test_ending,
  input  logic                          test_has_ended,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [DCT_W-1:0]              rd_data,
  output logic [CNT_W-1:0]              rd_count,
  output logic [lvl_width(DEPTH)-1:0]   level,
  output logic                          overflow,
  output logic [TOT_W-1:0]              total,
  output logic [1:0]                    state,
  output logic                          done
);

  localparam int LW = lvl_width(DEPTH);
  localparam int FW = CNT_W + DCT_W;

  dct_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             overflow_q, overflow_d;
  logic [TOT_W-1:0] total_q, total_d;

  logic             capture_s;
  logic             push_s;
  logic             pop_s;
  logic             push_ok_s;
  logic             flush_s;
  logic             drain_empty_s;
  logic             valid_s;
  logic [FW-1:0]    head_s;
  logic [LW-1:0]    level_s;
  logic             empty_s;
  logic             full_s;

  nios2_oci_dct_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .data_i  ({dct_count, dct_buffer}),
    .head_o  (head_s),
    .level_o (level_s),
    .empty_o (empty_s),
    .full_o  (full_s)
  );

  assign capture_s = (state_q == ST_RUN) && (dct_count != cnt_q);
  assign push_s    = capture_s && !flush_s;
  assign pop_s     = valid_s && rd_ready;
  assign push_ok_s = push_s && (!full_s || pop_s);

  // Nothing is pushed while draining, so the FIFO empties exactly when the
  // last word pops or when it is already empty.
  assign drain_empty_s = empty_s || ((level_s == LW'(1)) && pop_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (test_has_ended) begin
          state_d = ST_DONE;
        end else if (test_ending) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (test_has_ended || drain_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    flush_s  = (state_q != ST_DONE) && (state_d == ST_DONE);
    valid_s  = !empty_s && (state_q != ST_DONE);
    rd_valid = valid_s;
    if (valid_s) begin
      rd_data  = head_s[DCT_W-1:0];
      rd_count = head_s[FW-1:DCT_W];
    end else begin
      rd_data  = '0;
      rd_count = '0;
    end
    level = level_s;
    state = state_q;
    done  = (state_q == ST_DONE);
  end

  always_comb begin
    overflow_d = overflow_q;
    total_d    = total_q;
    if (push_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if (push_ok_s && (total_q != {TOT_W{1'b1}})) begin
      total_d = total_q + TOT_W'(1);
    end else begin
      total_d = total_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      cnt_q      <= dct_count;
      overflow_q <= overflow_d;
      total_q    <= total_d;
    end
  end

  assign overflow = overflow_q;
  assign total    = total_q;

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Directed bench for nios2_oci_dct_capture with a 4-entry FIFO.
module tb_nios2_oci_dct_capture;

  localparam int DCT_W = 30;
  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  localparam int TOT_W = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [DCT_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             test_ending;
  logic             test_has_ended;
  logic             rd_ready;
  logic             rd_valid;
  logic [DCT_W-1:0] rd_data;
  logic [CNT_W-1:0] rd_count;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [TOT_W-1:0] total;
  logic [1:0]       state;
  logic             done;

  int errors = 0;
  int checks = 0;

  nios2_oci_dct_capture #(
    .DCT_W (DCT_W),
    .CNT_W (CNT_W),
    .DEPTH (DEPTH),
    .TOT_W (TOT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_count       (rd_count),
    .level          (level),
    .overflow       (overflow),
    .total          (total),
    .state          (state),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    dct_buffer     = '0;
    dct_count      = '0;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    rd_ready       = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic push_word(input logic [CNT_W-1:0] c, input logic [DCT_W-1:0] d);
    dct_count  = c;
    dct_buffer = d;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%0h exp=0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    checks++; if (rd_count !== '0) begin errors++; $display("FAIL reset_rd_count got=%0h exp=0", rd_count); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
    checks++; if (total !== '0) begin errors++; $display("FAIL reset_total got=%0d exp=0", total); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", done); end
  endtask

  task automatic test_capture();
    apply_reset();
    push_word(4'd1, 30'h1);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL cap_latency_valid got=%0h exp=1", rd_valid); end
    push_word(4'd2, 30'h2);
    step();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL cap_level got=%0d exp=2", level); end
    checks++; if (total !== 32'd2) begin errors++; $display("FAIL cap_total got=%0d exp=2", total); end
    checks++; if ({rd_count, rd_data} !== {4'd1, 30'h1}) begin errors++; $display("FAIL cap_head0 got=%0h/%0h exp=1/1", rd_count, rd_data); end
    rd_ready = 1'b1;
    step();
    checks++; if ({rd_count, rd_data} !== {4'd2, 30'h2}) begin errors++; $display("FAIL cap_head1 got=%0h/%0h exp=2/2", rd_count, rd_data); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL cap_level_pop got=%0d exp=1", level); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL cap_empty_valid got=%0h exp=0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL cap_empty_data got=%0h exp=0", rd_data); end
    rd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 5; i++) push_word(CNT_W'(i), DCT_W'(32'h10 + i));
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", level); end
    checks++; if (total !== 32'd4) begin errors++; $display("FAIL ovf_total got=%0d exp=4", total); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ((rd_count !== CNT_W'(i)) || (rd_data !== DCT_W'(32'h10 + i))) begin
        errors++;
        $display("FAIL ovf_read%0d got=%0h/%0h exp=%0h/%0h", i, rd_count, rd_data, i, 32'h10 + i);
      end
      step();
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovf_drained_level got=%0d exp=0", level); end
    rd_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 1; i <= 4; i++) push_word(CNT_W'(i), DCT_W'(32'h10 + i));
    rd_ready = 1'b1;
    push_word(4'd5, 30'h55);
    rd_ready = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level got=%0d exp=4", level); end
    checks++; if (total !== 32'd5) begin errors++; $display("FAIL fullpop_total got=%0d exp=5", total); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got=%0h exp=0", overflow); end
    checks++; if ({rd_count, rd_data} !== {4'd2, 30'h12}) begin errors++; $display("FAIL fullpop_head got=%0h/%0h exp=2/12", rd_count, rd_data); end
  endtask

  task automatic test_drain();
    apply_reset();
    for (int i = 1; i <= 3; i++) push_word(CNT_W'(i), DCT_W'(32'h20 + i));
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL drain_state got=%0d exp=1", state); end
    dct_count = 4'd9;
    rd_ready  = 1'b1;
    step();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL drain_level got=%0d exp=2", level); end
    checks++; if (total !== 32'd3) begin errors++; $display("FAIL drain_total_ignored got=%0d exp=3", total); end
    dct_count = 4'd10;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL drain_state_mid got=%0d exp=1", state); end
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL drain_done_state got=%0d exp=2", state); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL drain_done got=%0h exp=1", done); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%0h exp=0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL drain_overflow got=%0h exp=0", overflow); end
    rd_ready = 1'b0;
  endtask

  task automatic test_forced_end();
    apply_reset();
    push_word(4'd1, 30'h31);
    push_word(4'd2, 30'h32);
    test_ending    = 1'b1;
    test_has_ended = 1'b1;
    step();
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL forced_state got=%0d exp=2", state); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL forced_done got=%0h exp=1", done); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL forced_level got=%0d exp=0", level); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL forced_valid got=%0h exp=0", rd_valid); end
    checks++; if (total !== 32'd2) begin errors++; $display("FAIL forced_total got=%0d exp=2", total); end
    push_word(4'd7, 30'h37);
    checks++; if ((state !== 2'd2) || (total !== 32'd2) || (level !== 3'd0)) begin errors++; $display("FAIL done_hold got=%0d/%0d/%0d exp=2/2/0", state, total, level); end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    push_word(4'd1, 30'h41);
    push_word(4'd2, 30'h42);
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    checks++; if ((state !== 2'd1) || (level !== 3'd2)) begin errors++; $display("FAIL mid_setup got=%0d/%0d exp=1/2", state, level); end
    reset = 1'b1;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_state got=%0d exp=0", state); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level got=%0d exp=0", level); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0h exp=0", rd_valid); end
    checks++; if (total !== '0) begin errors++; $display("FAIL mid_total got=%0d exp=0", total); end
    checks++; if ((rd_data !== '0) || (rd_count !== '0) || (done !== 1'b0) || (overflow !== 1'b0)) begin errors++; $display("FAIL mid_misc got=%0h/%0h/%0h/%0h exp=0/0/0/0", rd_data, rd_count, done, overflow); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_full_pop();
    test_drain();
    test_forced_end();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
